// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline: fetch FSM encodings,
// the canonical NOP and the reset fetch address.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request outstanding at PC
        S_HOLD = 2'd1,  // response parked in skid buffer while stalled
        S_DROP = 2'd2   // waiting out a request abandoned by a redirect
    } fetch_state_t;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Flush (or reset) inserts a NOP bubble, stall holds, otherwise it loads.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // Bubble on reset/flush, hold on stall, capture a new instruction otherwise
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= in_instr;
            pc4   <= in_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: fetch PC register, instruction-memory req/ack sequencer,
// one-entry skid buffer for responses arriving under stall, and the
// IF/ID pipeline register.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Next_PC_IF,
    input  logic        Flush_IF,
    input  logic        Stall_IF,
    output logic [31:0] PC_Plus_4_IF,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Rdata,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PC_Plus_4_ID,
    output logic        Valid_ID
);

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic [31:0] redirect_pc;

    // Decoded per-cycle actions
    logic        pc_load;
    logic [31:0] pc_next;
    logic        skid_load;
    logic        redirect_load;
    logic        ifid_stall;
    logic        ifid_flush;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;

    // PC+4 wraps naturally at 2^32
    assign PC_Plus_4_IF = pc + 32'd4;

    // A request is outstanding whenever we are not parked in the skid
    // buffer; it is only ever withdrawn by reset.
    assign Imem_Req  = !Reset && (state != S_HOLD);
    assign Imem_Addr = pc;

    // Next-state and per-cycle action decode; priority is Flush over Stall
    always_comb begin
        state_next    = state;
        pc_load       = 1'b0;
        pc_next       = Next_PC_IF;
        skid_load     = 1'b0;
        redirect_load = 1'b0;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr    = Imem_Rdata;
        ifid_pc4      = PC_Plus_4_IF;

        case (state)
            S_REQ: begin
                if (Imem_Ack) begin
                    if (Flush_IF) begin
                        // Fetched instruction is on the wrong path
                        ifid_flush = 1'b1;
                        pc_load    = 1'b1;
                    end else if (Stall_IF) begin
                        // Response cannot enter IF/ID yet; park it
                        skid_load  = 1'b1;
                        ifid_stall = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        pc_load    = 1'b1;
                    end
                end else begin
                    if (Flush_IF) begin
                        // Request cannot be withdrawn; remember the target
                        redirect_load = 1'b1;
                        ifid_flush    = 1'b1;
                        state_next    = S_DROP;
                    end else if (Stall_IF) begin
                        ifid_stall = 1'b1;
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end
            end

            S_DROP: begin
                if (Stall_IF && !Flush_IF) begin
                    ifid_stall = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end

                if (Imem_Ack) begin
                    // Abandoned response arrives; discard it and redirect
                    pc_load    = 1'b1;
                    pc_next    = Flush_IF ? Next_PC_IF : redirect_pc;
                    state_next = S_REQ;
                end else if (Flush_IF) begin
                    redirect_load = 1'b1;
                end
            end

            S_HOLD: begin
                if (Flush_IF) begin
                    ifid_flush = 1'b1;
                    pc_load    = 1'b1;
                    state_next = S_REQ;
                end else if (Stall_IF) begin
                    ifid_stall = 1'b1;
                end else begin
                    // Release the parked instruction into IF/ID
                    ifid_instr = skid_instr;
                    ifid_pc4   = skid_pc4;
                    pc_load    = 1'b1;
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_REQ;
                ifid_flush = 1'b1;
            end
        endcase
    end

    // Fetch state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC; loaded addresses are forced word aligned
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= align_word(pc_next);
        end
    end

    // Skid buffer holding a response that arrived during a stall
    always_ff @(posedge Clk) begin
        if (Reset) begin
            skid_instr <= NOP_INSTR;
            skid_pc4   <= 32'h0;
        end else if (skid_load) begin
            skid_instr <= Imem_Rdata;
            skid_pc4   <= PC_Plus_4_IF;
        end
    end

    // Redirect target captured while an abandoned request drains
    always_ff @(posedge Clk) begin
        if (Reset) begin
            redirect_pc <= 32'h0;
        end else if (redirect_load) begin
            redirect_pc <= Next_PC_IF;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (Clk),
        .rst      (Reset),
        .stall    (ifid_stall),
        .flush    (ifid_flush),
        .in_instr (ifid_instr),
        .in_pc4   (ifid_pc4),
        .instr    (Instruction_ID),
        .pc4      (PC_Plus_4_ID),
        .valid    (Valid_ID)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for the IF fetch stage.
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Next_PC_IF;
    logic        Flush_IF;
    logic        Stall_IF;
    logic [31:0] PC_Plus_4_IF;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Rdata;
    logic [31:0] Instruction_ID;
    logic [31:0] PC_Plus_4_ID;
    logic        Valid_ID;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Next_PC_IF     (Next_PC_IF),
        .Flush_IF       (Flush_IF),
        .Stall_IF       (Stall_IF),
        .PC_Plus_4_IF   (PC_Plus_4_IF),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Ack       (Imem_Ack),
        .Imem_Rdata     (Imem_Rdata),
        .Instruction_ID (Instruction_ID),
        .PC_Plus_4_ID   (PC_Plus_4_ID),
        .Valid_ID       (Valid_ID)
    );

    always #5 Clk = ~Clk;

    // One cycle: inputs held for the cycle, expected request outputs before
    // the edge (ca=0: address not checked), expected IF/ID after the edge.
    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] npc;
        logic        exp_req;
        logic        ca;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic flush, input logic stall,
                                input logic ack, input logic [31:0] rdata, input logic [31:0] npc,
                                input logic exp_req, input logic ca, input logic [31:0] exp_addr,
                                input logic [31:0] exp_instr, input logic [31:0] exp_pc4,
                                input logic exp_valid);
        vec_t v;
        v.rst = rst; v.flush = flush; v.stall = stall; v.ack = ack;
        v.rdata = rdata; v.npc = npc; v.exp_req = exp_req; v.ca = ca;
        v.exp_addr = exp_addr; v.exp_instr = exp_instr; v.exp_pc4 = exp_pc4;
        v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic flush, input logic stall,
                         input logic ack, input logic [31:0] rdata, input logic [31:0] npc);
        Reset = rst; Flush_IF = flush; Stall_IF = stall;
        Imem_Ack = ack; Imem_Rdata = rdata; Next_PC_IF = npc;
    endtask

    initial begin
        //          rst fl st ack rdata         npc           req ca addr          instr         pc4           vld
        // reset state
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 32'h0,        32'h0,        0);
        // streaming with same-cycle ack
        vecs[1]  = mk(0, 0, 0, 1, 32'hA000_0000, 32'h0000_0004, 1, 1, 32'h0000_0000, 32'hA000_0000, 32'h0000_0004, 1);
        vecs[2]  = mk(0, 0, 0, 1, 32'hA000_0004, 32'h0000_0008, 1, 1, 32'h0000_0004, 32'hA000_0004, 32'h0000_0008, 1);
        vecs[3]  = mk(0, 0, 0, 1, 32'hA000_0008, 32'h0000_000C, 1, 1, 32'h0000_0008, 32'hA000_0008, 32'h0000_000C, 1);
        // ack delayed three cycles: bubbles, request held stable
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0010, 1, 1, 32'h0000_000C, 32'h0,        32'h0,        0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0010, 1, 1, 32'h0000_000C, 32'h0,        32'h0,        0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        32'h0000_0010, 1, 1, 32'h0000_000C, 32'h0,        32'h0,        0);
        vecs[7]  = mk(0, 0, 0, 1, 32'hA000_000C, 32'h0000_0010, 1, 1, 32'h0000_000C, 32'hA000_000C, 32'h0000_0010, 1);
        // ack with stall at 0x10: park in skid, IF/ID holds, then release
        vecs[8]  = mk(0, 0, 1, 1, 32'hB000_0010, 32'h0000_0014, 1, 1, 32'h0000_0010, 32'hA000_000C, 32'h0000_0010, 1);
        vecs[9]  = mk(0, 0, 1, 0, 32'h0,        32'h0000_0014, 0, 0, 32'h0,        32'hA000_000C, 32'h0000_0010, 1);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,        32'h0000_0014, 0, 0, 32'h0,        32'hA000_000C, 32'h0000_0010, 1);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,        32'h0000_0014, 0, 0, 32'h0,        32'hB000_0010, 32'h0000_0014, 1);
        vecs[12] = mk(0, 0, 0, 1, 32'hA000_0014, 32'h0000_0018, 1, 1, 32'h0000_0014, 32'hA000_0014, 32'h0000_0018, 1);
        vecs[13] = mk(0, 0, 0, 1, 32'hA000_0018, 32'h0000_0020, 1, 1, 32'h0000_0018, 32'hA000_0018, 32'h0000_001C, 1);
        // flush to 0x400 while 0x20 pending; DEADBEEF must be dropped
        vecs[14] = mk(0, 1, 0, 0, 32'h0,        32'h0000_0400, 1, 1, 32'h0000_0020, 32'h0,        32'h0,        0);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,        32'h0000_0024, 1, 1, 32'h0000_0020, 32'h0,        32'h0,        0);
        vecs[16] = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h0000_0024, 1, 1, 32'h0000_0020, 32'h0,        32'h0,        0);
        vecs[17] = mk(0, 0, 0, 1, 32'hA000_0400, 32'h0000_0404, 1, 1, 32'h0000_0400, 32'hA000_0400, 32'h0000_0404, 1);
        // two flushes in the drop state, second with the ack: 0x800 wins
        vecs[18] = mk(0, 1, 0, 0, 32'h0,        32'h0000_0400, 1, 1, 32'h0000_0404, 32'h0,        32'h0,        0);
        vecs[19] = mk(0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0000_0800, 1, 1, 32'h0000_0404, 32'h0,        32'h0,        0);
        vecs[20] = mk(0, 0, 0, 1, 32'hA000_0800, 32'h0000_0804, 1, 1, 32'h0000_0800, 32'hA000_0800, 32'h0000_0804, 1);
        // misaligned next PC is forced to a word boundary
        vecs[21] = mk(0, 0, 0, 1, 32'hA000_0804, 32'h0000_0903, 1, 1, 32'h0000_0804, 32'hA000_0804, 32'h0000_0808, 1);
        vecs[22] = mk(0, 0, 0, 1, 32'hA000_0900, 32'h0000_0904, 1, 1, 32'h0000_0900, 32'hA000_0900, 32'h0000_0904, 1);
        // flush beats stall while parked in the skid buffer
        vecs[23] = mk(0, 0, 1, 1, 32'hC000_0904, 32'h0000_0908, 1, 1, 32'h0000_0904, 32'hA000_0900, 32'h0000_0904, 1);
        vecs[24] = mk(0, 1, 1, 0, 32'h0,        32'h0000_0A00, 0, 0, 32'h0,        32'h0,        32'h0,        0);
        vecs[25] = mk(0, 0, 0, 1, 32'hA000_0A00, 32'h0000_0A04, 1, 1, 32'h0000_0A00, 32'hA000_0A00, 32'h0000_0A04, 1);
        // ack together with flush: data discarded, PC redirected
        vecs[26] = mk(0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0000_0B00, 1, 1, 32'h0000_0A04, 32'h0,        32'h0,        0);
        vecs[27] = mk(0, 0, 0, 1, 32'hA000_0B00, 32'h0000_0B04, 1, 1, 32'h0000_0B00, 32'hA000_0B00, 32'h0000_0B04, 1);

        drive(1, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge Clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].ack, vecs[i].rdata, vecs[i].npc);
            #1;
            check($sformatf("v%0d Imem_Req", i), {31'h0, Imem_Req}, {31'h0, vecs[i].exp_req});
            if (vecs[i].ca) begin
                check($sformatf("v%0d Imem_Addr", i), Imem_Addr, vecs[i].exp_addr);
                check($sformatf("v%0d PC_Plus_4_IF", i), PC_Plus_4_IF, vecs[i].exp_addr + 32'd4);
            end
            @(posedge Clk);
            #1;
            check($sformatf("v%0d Instruction_ID", i), Instruction_ID, vecs[i].exp_instr);
            check($sformatf("v%0d PC_Plus_4_ID", i), PC_Plus_4_ID, vecs[i].exp_pc4);
            check($sformatf("v%0d Valid_ID", i), {31'h0, Valid_ID}, {31'h0, vecs[i].exp_valid});
        end

        // PC at the top of the address space: PC+4 wraps to zero
        drive(0, 0, 0, 1, 32'hA000_0B04, 32'hFFFF_FFFC);
        @(posedge Clk);
        #1;
        check("wrap Instruction_ID", Instruction_ID, 32'hA000_0B04);
        check("wrap Imem_Addr", Imem_Addr, 32'hFFFF_FFFC);
        check("wrap PC_Plus_4_IF", PC_Plus_4_IF, 32'h0000_0000);

        // Park in the skid buffer, then reset while held
        drive(0, 0, 1, 1, 32'h1234_5678, 32'h0000_0000);
        @(posedge Clk);
        #1;
        check("hold Imem_Req", {31'h0, Imem_Req}, 32'h0);
        check("hold Valid_ID", {31'h0, Valid_ID}, 32'h1);
        check("hold Instruction_ID", Instruction_ID, 32'hA000_0B04);

        drive(1, 0, 1, 0, 32'h0, 32'h0);
        #1;
        check("rst Imem_Req low", {31'h0, Imem_Req}, 32'h0);
        @(posedge Clk);
        #1;
        check("rst Valid_ID", {31'h0, Valid_ID}, 32'h0);
        check("rst Instruction_ID", Instruction_ID, 32'h0);
        check("rst PC_Plus_4_ID", PC_Plus_4_ID, 32'h0);
        check("rst Imem_Addr", Imem_Addr, 32'h0);
        check("rst PC_Plus_4_IF", PC_Plus_4_IF, 32'h4);

        // After reset release a fresh request at RESET_PC (state S_REQ)
        drive(0, 0, 0, 0, 32'h0, 32'h4);
        #1;
        check("post-rst Imem_Req", {31'h0, Imem_Req}, 32'h1);
        check("post-rst Imem_Addr", Imem_Addr, 32'h0);
        @(posedge Clk);
        #1;
        check("post-rst Valid_ID", {31'h0, Valid_ID}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
